// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential radix-2 Booth multiplier, one iteration per clock,
// registered 2*WIDTH-bit signed product with a one-cycle done pulse.
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               masterrst,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  typedef enum logic {IDLE, CALC} state_t;
  state_t r_state, w_next;
  logic [WIDTH:0]   r_a, r_m, w_sum;
  logic [WIDTH-1:0] r_q;
  logic             r_q1;
  logic [CW-1:0]    r_cnt;
  logic             w_last, w_accept;
  // A carries one guard bit so that subtracting M = -2^(WIDTH-1) cannot overflow
  assign w_sum = ({r_q[0], r_q1} == 2'b01) ? r_a + r_m :
                 ({r_q[0], r_q1} == 2'b10) ? r_a - r_m : r_a;
  assign w_last   = r_cnt == CW'(1);
  assign w_accept = r_state == IDLE && start;
  assign busy     = r_state == CALC;
  always_ff @(posedge clk) r_state <= masterrst ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = CALC;
    if (r_state == CALC && w_last) w_next = IDLE;
  end
  always_ff @(posedge clk) begin
    if (masterrst) begin
      r_a     <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_q1    <= 1'b0;
      r_cnt   <= '0;
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_a   <= '0;
        r_q   <= multiplier;
        r_q1  <= 1'b0;
        r_m   <= {multiplicand[WIDTH-1], multiplicand};
        r_cnt <= CNT_INIT;
      end else if (r_state == CALC) begin
        r_a   <= {w_sum[WIDTH], w_sum[WIDTH:1]};
        r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
        r_q1  <= r_q[0];
        r_cnt <= r_cnt - 1'b1;
        // low 2*WIDTH bits of the shifted {A,Q}
        if (w_last) begin
          product <= {w_sum, r_q[WIDTH-1:1]};
          done    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: directed and random checks of booth_mult_seq at WIDTH=8 and WIDTH=5.
module tb_booth_mult_seq;
  logic clk = 1'b0;
  logic masterrst = 1'b1;
  logic start8 = 1'b0;
  logic [7:0] m8 = '0, q8 = '0;
  logic [15:0] p8;
  logic busy8, done8;
  logic start5 = 1'b0;
  logic [4:0] m5 = '0, q5 = '0;
  logic [9:0] p5;
  logic busy5, done5;
  int n_checks = 0, n_pass = 0, n_fail = 0;

  always #5 clk = ~clk;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .masterrst(masterrst), .start(start8), .multiplicand(m8),
    .multiplier(q8), .product(p8), .busy(busy8), .done(done8));

  booth_mult_seq #(.WIDTH(5)) dut5 (
    .clk(clk), .masterrst(masterrst), .start(start5), .multiplicand(m5),
    .multiplier(q5), .product(p5), .busy(busy5), .done(done5));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Starts an 8-bit multiply from an IDLE cycle and returns in its done cycle.
  // poke >= 0 raises start (9*9) during that CALC cycle, which must be ignored.
  task automatic op8(input string tag, input logic [7:0] m, input logic [7:0] q,
                     input logic [15:0] exp, input int poke);
    int n = 0;
    logic bad_busy = 1'b0, bad_hold = 1'b0;
    logic [15:0] prev = p8;
    start8 = 1'b1; m8 = m; q8 = q;
    step();
    start8 = 1'b0; m8 = ~m; q8 = ~q;
    while (!done8 && n < 40) begin
      if (!busy8) bad_busy = 1'b1;
      if (p8 !== prev) bad_hold = 1'b1;
      if (n == poke) begin start8 = 1'b1; m8 = 8'd9; q8 = 8'd9; end
      step();
      start8 = 1'b0;
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd8);
    check({tag, " busy_during"}, 64'(bad_busy), 64'd0);
    check({tag, " product_hold"}, 64'(bad_hold), 64'd0);
    check({tag, " busy_at_done"}, 64'(busy8), 64'd0);
    check({tag, " product"}, 64'(p8), 64'(exp));
  endtask

  task automatic op5(input logic [4:0] m, input logic [4:0] q, input logic [9:0] exp);
    int n = 0;
    start5 = 1'b1; m5 = m; q5 = q;
    step();
    start5 = 1'b0; m5 = ~m; q5 = ~q;
    while (!done5 && n < 40) begin
      step();
      n++;
    end
    check("rand5 latency", 64'(n), 64'd5);
    check("rand5 product", 64'(p5), 64'(exp));
  endtask

  initial begin
    int dones;
    int e;
    logic [7:0] rm8, rq8;
    logic [4:0] rm5, rq5;
    step(); step();
    check("reset product8", 64'(p8), 64'd0);
    check("reset busy8", 64'(busy8), 64'd0);
    check("reset done8", 64'(done8), 64'd0);
    check("reset product5", 64'(p5), 64'd0);
    masterrst = 1'b0;
    step();
    op8("t1 3*5", 8'd3, 8'd5, 16'h000F, -1);
    step();
    check("t1 done_pulse_end", 64'(done8), 64'd0);
    op8("t2 -7*3", 8'hF9, 8'h03, 16'hFFEB, -1);
    op8("t2 min*min", 8'h80, 8'h80, 16'h4000, -1);
    op8("t2 max*min", 8'h7F, 8'h80, 16'hC080, -1);
    step();
    op8("t3 ignore_start", 8'd2, 8'd2, 16'h0004, 3);
    dones = 0;
    repeat (12) begin step(); if (done8) dones++; end
    check("t3 no_extra_done", 64'(dones), 64'd0);
    start8 = 1'b1; m8 = 8'd10; q8 = 8'd10;
    step();
    start8 = 1'b0;
    repeat (4) step();
    masterrst = 1'b1;
    step();
    masterrst = 1'b0;
    check("t4 busy_after_rst", 64'(busy8), 64'd0);
    check("t4 done_after_rst", 64'(done8), 64'd0);
    check("t4 product_after_rst", 64'(p8), 64'd0);
    dones = 0;
    repeat (12) begin step(); if (done8) dones++; end
    check("t4 no_done", 64'(dones), 64'd0);
    op8("t4 1*-1", 8'd1, 8'hFF, 16'hFFFF, -1);
    step();
    op8("t5 6*-4", 8'd6, 8'hFC, 16'hFFE8, -1);
    op8("t5 b2b -5*-5", 8'hFB, 8'hFB, 16'h0019, -1);
    step();
    for (int i = 0; i < 1000; i++) begin
      rm8 = 8'($urandom);
      rq8 = 8'($urandom);
      e = int'($signed(rm8)) * int'($signed(rq8));
      op8("rand8", rm8, rq8, 16'(e), -1);
    end
    for (int i = 0; i < 1000; i++) begin
      rm5 = 5'($urandom);
      rq5 = 5'($urandom);
      e = int'($signed(rm5)) * int'($signed(rq5));
      op5(rm5, rq5, 10'(e));
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
